// File: rtl/cnn_axil_loader_pkg.sv
// Shared register map, status bit positions, response codes and run-state
// encoding for the AXI4-Lite CNN loader.
package cnn_axil_pkg;

    // Word indices (byte address bits [ADDR_W-1:2])
    localparam int W_CTRL   = 0;
    localparam int W_STATUS = 1;
    localparam int W_RESULT = 2;
    localparam int W_IRQ    = 3;
    localparam int W_DATA0  = 4;   // DATA[c] at W_DATA0+c, LEN[c] at W_DATA0+N_CH+c

    // CTRL / IRQ bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_CLR   = 1;
    localparam int IRQ_PEND   = 0;
    localparam int IRQ_EN     = 1;

    // STATUS bit positions
    localparam int ST_DONE   = 0;
    localparam int ST_BUSY   = 1;
    localparam int ST_ERR    = 2;
    localparam int ST_LOADED = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/cnn_load_ch_cnt.sv
// One load channel: programmable length, auto-increment word counter and a
// registered memory write strobe/address that trails the accepted bus write.
module cnn_load_ch_cnt #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              len_we,
    input  logic [MEM_AW:0]   len_wdata,
    input  logic              data_we,
    input  logic              cnt_clr,
    output logic [MEM_AW:0]   len,
    output logic              full,
    output logic              loaded,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr
);

    localparam logic [MEM_AW:0] CNT_ONE = {{MEM_AW{1'b0}}, 1'b1};

    logic [MEM_AW:0]   len_reg;
    logic [MEM_AW:0]   cnt_reg;
    logic              mem_we_reg;
    logic [MEM_AW-1:0] mem_addr_reg;

    // Length register, counter and one-cycle write strobe at the pre-increment count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_reg      <= '0;
            cnt_reg      <= '0;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= '0;
        end else begin
            mem_we_reg <= 1'b0;
            if (len_we) begin
                len_reg <= len_wdata;
            end
            if (cnt_clr) begin
                cnt_reg <= '0;
            end else if (data_we) begin
                cnt_reg      <= cnt_reg + CNT_ONE;
                mem_we_reg   <= 1'b1;
                mem_addr_reg <= cnt_reg[MEM_AW-1:0];
            end
        end
    end

    assign len      = len_reg;
    assign full     = (cnt_reg >= len_reg);
    assign loaded   = (cnt_reg == len_reg) && (len_reg != '0);
    assign mem_we   = mem_we_reg;
    assign mem_addr = mem_addr_reg;

endmodule

// File: rtl/cnn_axil_loader.sv
// AXI4-Lite slave front-end for the CNN core: per-channel streaming loads,
// run FSM, result capture and a maskable level interrupt.
module cnn_axil_loader
    import cnn_axil_pkg::*;
#(
    parameter int N_CH   = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int MEM_AW = 12,
    parameter int RES_W  = 4
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [ADDR_W-1:0]      s_awaddr,
    input  logic                   s_awvalid,
    output logic                   s_awready,
    input  logic [DATA_W-1:0]      s_wdata,
    input  logic [DATA_W/8-1:0]    s_wstrb,
    input  logic                   s_wvalid,
    output logic                   s_wready,
    output logic [1:0]             s_bresp,
    output logic                   s_bvalid,
    input  logic                   s_bready,
    input  logic [ADDR_W-1:0]      s_araddr,
    input  logic                   s_arvalid,
    output logic                   s_arready,
    output logic [DATA_W-1:0]      s_rdata,
    output logic [1:0]             s_rresp,
    output logic                   s_rvalid,
    input  logic                   s_rready,
    output logic [N_CH-1:0]        mem_we,
    output logic [N_CH*MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic                   core_start,
    output logic                   core_clr,
    input  logic                   core_done,
    input  logic [RES_W-1:0]       core_result,
    output logic                   irq
);

    state_t            state_reg;
    logic              awready_reg, bvalid_reg, arready_reg, rvalid_reg;
    logic [1:0]        bresp_reg;
    logic [DATA_W-1:0] rdata_reg, rd_mux, mem_wdata_reg;
    logic              err_reg, irq_pend_reg, irq_en_reg;
    logic              core_start_reg, core_clr_reg;
    logic [RES_W-1:0]  result_reg;

    logic              wr_fire, rd_fire;
    logic [31:0]       wr_word, rd_word;
    logic [N_CH-1:0]   data_hit, data_acc, len_hit, len_we, full_vec, loaded_vec;
    logic [MEM_AW:0]   len_arr [N_CH];
    logic              ctrl_hit, irq_hit, clr_cmd, start_cmd, can_load, loaded_all;
    logic              data_err, len_err, start_err, wr_err;
    logic              unused_ok;

    // Byte-lane strobes and sub-word address bits carry no meaning here
    assign unused_ok = ^{s_wstrb, s_awaddr[1:0], s_araddr[1:0]};

    assign wr_fire = awready_reg & s_awvalid & s_wvalid;
    assign rd_fire = arready_reg & s_arvalid;
    assign wr_word = 32'(s_awaddr[ADDR_W-1:2]);
    assign rd_word = 32'(s_araddr[ADDR_W-1:2]);

    assign ctrl_hit   = wr_fire && (wr_word == W_CTRL);
    assign irq_hit    = wr_fire && (wr_word == W_IRQ);
    assign clr_cmd    = ctrl_hit && s_wdata[CTRL_CLR];
    assign start_cmd  = ctrl_hit && s_wdata[CTRL_START] && !s_wdata[CTRL_CLR];
    assign can_load   = (state_reg == S_IDLE) || (state_reg == S_LOAD);
    assign loaded_all = &loaded_vec;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign data_hit[gi] = wr_fire && (wr_word == W_DATA0 + gi);
            assign len_hit[gi]  = wr_fire && (wr_word == W_DATA0 + N_CH + gi);
            assign data_acc[gi] = data_hit[gi] && can_load && !full_vec[gi];
            assign len_we[gi]   = len_hit[gi] && (state_reg == S_IDLE);

            cnn_load_ch_cnt #(.MEM_AW(MEM_AW)) u_cnt (
                .clk       (ACLK),
                .rst       (ARESET),
                .len_we    (len_we[gi]),
                .len_wdata (s_wdata[MEM_AW:0]),
                .data_we   (data_acc[gi]),
                .cnt_clr   (clr_cmd),
                .len       (len_arr[gi]),
                .full      (full_vec[gi]),
                .loaded    (loaded_vec[gi]),
                .mem_we    (mem_we[gi]),
                .mem_addr  (mem_addr[gi*MEM_AW +: MEM_AW])
            );
        end
    endgenerate

    assign data_err  = |(data_hit & ~data_acc);
    assign len_err   = (|len_hit) && (state_reg != S_IDLE);
    assign start_err = start_cmd && !(can_load && loaded_all);
    assign wr_err    = data_err || len_err || start_err;

    // Read data selection for the word presented on the AR channel
    always_comb begin
        rd_mux = '0;
        if (rd_word == W_STATUS) begin
            rd_mux[ST_DONE]   = (state_reg == S_DONE);
            rd_mux[ST_BUSY]   = (state_reg == S_RUN);
            rd_mux[ST_ERR]    = err_reg;
            rd_mux[ST_LOADED] = loaded_all;
        end else if (rd_word == W_RESULT) begin
            rd_mux[RES_W-1:0] = result_reg;
        end else if (rd_word == W_IRQ) begin
            rd_mux[IRQ_PEND] = irq_pend_reg;
            rd_mux[IRQ_EN]   = irq_en_reg;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (rd_word == W_DATA0 + N_CH + i) begin
                rd_mux[MEM_AW:0] = len_arr[i];
            end
        end
    end

    // AXI4-Lite handshakes: one-cycle ready pulses, responses held until taken
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awready_reg   <= 1'b0;
            bvalid_reg    <= 1'b0;
            bresp_reg     <= RESP_OKAY;
            arready_reg   <= 1'b0;
            rvalid_reg    <= 1'b0;
            rdata_reg     <= '0;
            mem_wdata_reg <= '0;
        end else begin
            awready_reg <= s_awvalid && s_wvalid && !bvalid_reg && !awready_reg;
            if (wr_fire) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_bready) begin
                bvalid_reg <= 1'b0;
            end
            arready_reg <= s_arvalid && !rvalid_reg && !arready_reg;
            if (rd_fire) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_mux;
            end else if (s_rready) begin
                rvalid_reg <= 1'b0;
            end
            if (|data_acc) begin
                mem_wdata_reg <= s_wdata;
            end
        end
    end

    // Run FSM with sticky error, result capture, IRQ pend/enable and core pulses
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_reg      <= S_IDLE;
            err_reg        <= 1'b0;
            result_reg     <= '0;
            irq_pend_reg   <= 1'b0;
            irq_en_reg     <= 1'b0;
            core_start_reg <= 1'b0;
            core_clr_reg   <= 1'b0;
        end else begin
            core_start_reg <= 1'b0;
            core_clr_reg   <= 1'b0;
            if (irq_hit) begin
                irq_en_reg <= s_wdata[IRQ_EN];
                if (s_wdata[IRQ_PEND]) begin
                    irq_pend_reg <= 1'b0;
                end
            end
            if (clr_cmd) begin
                // Abort from any state; lengths, IRQ enable and result survive
                state_reg    <= S_IDLE;
                err_reg      <= 1'b0;
                core_clr_reg <= 1'b1;
            end else begin
                if (data_err || (start_err && can_load)) begin
                    err_reg <= 1'b1;
                end
                if (start_cmd && can_load && loaded_all) begin
                    state_reg      <= S_RUN;
                    core_start_reg <= 1'b1;
                end
                if ((|data_acc) && (state_reg == S_IDLE)) begin
                    state_reg <= S_LOAD;
                end
                if ((state_reg == S_RUN) && core_done) begin
                    state_reg    <= S_DONE;
                    result_reg   <= core_result;
                    irq_pend_reg <= 1'b1;   // overrides a same-cycle W1C
                end
            end
        end
    end

    assign s_awready  = awready_reg;
    assign s_wready   = awready_reg;
    assign s_bvalid   = bvalid_reg;
    assign s_bresp    = bresp_reg;
    assign s_arready  = arready_reg;
    assign s_rvalid   = rvalid_reg;
    assign s_rdata    = rdata_reg;
    assign s_rresp    = RESP_OKAY;
    assign mem_wdata  = mem_wdata_reg;
    assign core_start = core_start_reg;
    assign core_clr   = core_clr_reg;
    assign irq        = irq_pend_reg & irq_en_reg;

endmodule

// File: tb/tb_cnn_axil_loader.sv
// Randomized scoreboard bench for cnn_axil_loader: a register-level reference
// model predicts bus responses and memory writes; monitors pop and compare.
module tb_cnn_axil_loader;

    localparam int N_CH   = 3;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int MEM_AW = 12;
    localparam int RES_W  = 4;
    localparam int MS_IDLE = 0, MS_LOAD = 1, MS_RUN = 2, MS_DONE = 3;

    logic                   ACLK = 1'b0;
    logic                   ARESET = 1'b1;
    logic [ADDR_W-1:0]      s_awaddr = '0;
    logic                   s_awvalid = 1'b0;
    logic                   s_awready;
    logic [DATA_W-1:0]      s_wdata = '0;
    logic [DATA_W/8-1:0]    s_wstrb = '1;
    logic                   s_wvalid = 1'b0;
    logic                   s_wready;
    logic [1:0]             s_bresp;
    logic                   s_bvalid;
    logic                   s_bready = 1'b1;
    logic [ADDR_W-1:0]      s_araddr = '0;
    logic                   s_arvalid = 1'b0;
    logic                   s_arready;
    logic [DATA_W-1:0]      s_rdata;
    logic [1:0]             s_rresp;
    logic                   s_rvalid;
    logic                   s_rready = 1'b1;
    logic [N_CH-1:0]        mem_we;
    logic [N_CH*MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic                   core_start, core_clr;
    logic                   core_done = 1'b0;
    logic [RES_W-1:0]       core_result = '0;
    logic                   irq;

    cnn_axil_loader #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .RES_W(RES_W)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_start(core_start), .core_clr(core_clr),
        .core_done(core_done), .core_result(core_result), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        int          ch;
        int          addr;
        logic [31:0] data;
    } mw_t;

    mw_t         mq[$];
    logic [1:0]  bq[$];
    logic [31:0] rq[$];

    int m_len[N_CH];
    int m_cnt[N_CH];
    int m_state;
    logic m_err, m_pend, m_en;
    logic [RES_W-1:0] m_result;
    int start_exp = 0, clr_exp = 0, start_seen = 0, clr_seen = 0;
    int n_pass = 0, n_check = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_check++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endfunction

    function automatic void fail_now(input string nm);
        n_check++;
        $display("FAIL %s: got none expected event", nm);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_len[i] = 0;
            m_cnt[i] = 0;
        end
        m_state = MS_IDLE; m_err = 1'b0; m_pend = 1'b0; m_en = 1'b0; m_result = '0;
    endfunction

    function automatic logic m_loaded();
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < N_CH; i++)
            if (m_cnt[i] != m_len[i] || m_len[i] == 0) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [5:0] wa(input int w);
        return 6'(w * 4);
    endfunction

    // Predicted effect of one write; returns the expected response
    function automatic logic [1:0] model_wr(input logic [5:0] a, input logic [31:0] d);
        int w, c;
        logic [1:0] r;
        mw_t e;
        w = int'(a[5:2]);
        r = 2'b00;
        if (w == 0) begin
            if (d[1]) begin
                for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
                m_err = 1'b0; m_state = MS_IDLE; clr_exp++;
            end else if (d[0]) begin
                if (m_state <= MS_LOAD && m_loaded()) begin
                    m_state = MS_RUN; start_exp++;
                end else begin
                    r = 2'b10;
                    if (m_state <= MS_LOAD) m_err = 1'b1;
                end
            end
        end else if (w == 3) begin
            if (d[0]) m_pend = 1'b0;
            m_en = d[1];
        end else if (w >= 4 && w < 4 + N_CH) begin
            c = w - 4;
            if (m_state <= MS_LOAD && m_cnt[c] < m_len[c]) begin
                e.ch = c; e.addr = m_cnt[c]; e.data = d;
                mq.push_back(e);
                m_cnt[c]++;
                m_state = MS_LOAD;
            end else begin
                r = 2'b10; m_err = 1'b1;
            end
        end else if (w >= 4 + N_CH && w < 4 + 2 * N_CH) begin
            c = w - 4 - N_CH;
            if (m_state == MS_IDLE) m_len[c] = int'(d[12:0]);
            else r = 2'b10;
        end
        return r;
    endfunction

    function automatic logic [31:0] model_rd(input logic [5:0] a);
        int w;
        logic [31:0] v;
        w = int'(a[5:2]);
        v = '0;
        if (w == 1) v = {28'd0, m_loaded(), m_err, (m_state == MS_RUN), (m_state == MS_DONE)};
        else if (w == 2) v = 32'(m_result);
        else if (w == 3) v = {30'd0, m_en, m_pend};
        else if (w >= 4 + N_CH && w < 4 + 2 * N_CH) v = 32'(m_len[w - 4 - N_CH]);
        return v;
    endfunction

    task automatic axi_wr(input logic [5:0] a, input logic [31:0] d);
        int n;
        bq.push_back(model_wr(a, d));
        @(posedge ACLK); #1;
        s_awaddr = a; s_wdata = d; s_awvalid = 1'b1; s_wvalid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge ACLK);
            if (s_awready && s_wready) break;
            if (++n > 40) begin fail_now("aw_accept_timeout"); break; end
        end
        @(posedge ACLK); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n = 0;
        while (1) begin
            @(negedge ACLK);
            if (s_bvalid && s_bready) break;
            if (++n > 40) begin fail_now("b_timeout"); break; end
        end
        @(posedge ACLK); #1;
    endtask

    task automatic axi_rd(input logic [5:0] a);
        int n;
        rq.push_back(model_rd(a));
        @(posedge ACLK); #1;
        s_araddr = a; s_arvalid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge ACLK);
            if (s_arready) break;
            if (++n > 40) begin fail_now("ar_accept_timeout"); break; end
        end
        @(posedge ACLK); #1;
        s_arvalid = 1'b0;
        n = 0;
        while (1) begin
            @(negedge ACLK);
            if (s_rvalid && s_rready) break;
            if (++n > 40) begin fail_now("r_timeout"); break; end
        end
        @(posedge ACLK); #1;
    endtask

    task automatic pulse_done(input logic [RES_W-1:0] r);
        if (m_state == MS_RUN) begin
            m_result = r; m_state = MS_DONE; m_pend = 1'b1;
        end
        @(posedge ACLK); #1;
        core_done = 1'b1; core_result = r;
        @(posedge ACLK); #1;
        core_done = 1'b0;
    endtask

    task automatic stream(input int t0, input int t1, input int t2);
        int tgt[N_CH];
        int sent[N_CH];
        int c, total;
        tgt[0] = t0; tgt[1] = t1; tgt[2] = t2;
        total = t0 + t1 + t2;
        for (int i = 0; i < N_CH; i++) sent[i] = 0;
        for (int k = 0; k < total; k++) begin
            do c = int'($urandom_range(0, N_CH - 1)); while (sent[c] >= tgt[c]);
            axi_wr(wa(4 + c), $urandom);
            sent[c]++;
        end
    endtask

    // Response / memory-port monitor: pops the scoreboard on every handshake
    mw_t mon_e;
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (s_bvalid && s_bready) begin
                if (bq.size() == 0) fail_now("bresp_unexpected");
                else chk("bresp", 64'(s_bresp), 64'(bq.pop_front()));
            end
            if (s_rvalid && s_rready) begin
                if (rq.size() == 0) fail_now("rdata_unexpected");
                else begin
                    chk("rdata", 64'(s_rdata), 64'(rq.pop_front()));
                    chk("rresp", 64'(s_rresp), 64'(0));
                end
            end
            if (|mem_we) begin
                if (mq.size() == 0) begin
                    $display("FAIL mem_we_unexpected: got mem_we=0x%0h expected 0x0", mem_we);
                    n_check++;
                end else begin
                    mon_e = mq.pop_front();
                    chk("mem_we", 64'(mem_we), 64'(1) << mon_e.ch);
                    chk("mem_addr", 64'(mem_addr[mon_e.ch*MEM_AW +: MEM_AW]), 64'(mon_e.addr));
                    chk("mem_wdata", 64'(mem_wdata), 64'(mon_e.data));
                end
            end
            if (core_start) start_seen++;
            if (core_clr) clr_seen++;
        end
    end

    task automatic check_all_zero(input string nm);
        chk({nm, "_ctl"}, 64'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, mem_we, core_start, core_clr, irq}), 64'(0));
        chk({nm, "_bresp"}, 64'(s_bresp), 64'(0));
        chk({nm, "_rdata"}, 64'(s_rdata), 64'(0));
        chk({nm, "_mem_addr"}, 64'(mem_addr), 64'(0));
        chk({nm, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();
        repeat (3) @(posedge ACLK);
        #1 check_all_zero("reset");
        @(negedge ACLK) ARESET = 1'b0;

        axi_rd(wa(1));
        for (int c = 0; c < N_CH; c++) axi_rd(wa(4 + N_CH + c));

        // Round 1: full-size lengths, last fmap word held back
        axi_wr(wa(7), 32'd3220);
        axi_wr(wa(8), 32'd10);
        axi_wr(wa(9), 32'd784);
        for (int c = 0; c < N_CH; c++) axi_rd(wa(4 + N_CH + c));
        stream(3220, 10, 783);
        axi_rd(wa(1));
        axi_wr(wa(5), $urandom);           // 11th bias word: rejected
        axi_rd(wa(1));
        axi_wr(wa(0), 32'h1);              // start with fmap at 783: rejected
        chk("no_core_start_unloaded", 64'(start_seen), 64'(start_exp));
        axi_wr(wa(7), 32'd5);              // LEN write while loading: rejected
        axi_rd(wa(7));
        axi_wr(wa(6), $urandom);           // 784th fmap word
        axi_rd(wa(1));
        axi_wr(wa(0), 32'h1);
        repeat (3) @(negedge ACLK);
        chk("core_start_pulses", 64'(start_seen), 64'(start_exp));
        axi_rd(wa(1));

        // Completion, result capture and interrupt
        axi_wr(wa(3), 32'h2);
        pulse_done(4'd7);
        @(negedge ACLK);
        chk("irq_set", 64'(irq), 64'(m_pend & m_en));
        axi_rd(wa(2));
        axi_rd(wa(1));
        axi_rd(wa(3));
        pulse_done(4'd5);                  // outside RUN: ignored
        axi_rd(wa(2));
        axi_wr(wa(0), 32'h1);              // start in DONE: rejected
        axi_wr(wa(3), 32'h3);              // W1C pend, keep enable
        @(negedge ACLK);
        chk("irq_cleared", 64'(irq), 64'(m_pend & m_en));
        axi_wr(wa(0), 32'h2);
        repeat (2) @(negedge ACLK);
        chk("core_clr_pulses", 64'(clr_seen), 64'(clr_exp));
        axi_rd(wa(1));
        for (int c = 0; c < N_CH; c++) axi_rd(wa(4 + N_CH + c));

        // Round 2: small random lengths, then start|clr while running
        for (int c = 0; c < N_CH; c++) axi_wr(wa(4 + N_CH + c), 32'($urandom_range(1, 4)));
        stream(m_len[0], m_len[1], m_len[2]);
        axi_wr(wa(0), 32'h1);
        axi_rd(wa(1));
        axi_wr(wa(0), 32'h3);
        repeat (2) @(negedge ACLK);
        chk("abort_clr_pulses", 64'(clr_seen), 64'(clr_exp));
        chk("abort_start_pulses", 64'(start_seen), 64'(start_exp));
        axi_rd(wa(1));
        for (int c = 0; c < N_CH; c++) axi_rd(wa(4 + N_CH + c));

        // Back-pressure with concurrent write and read
        s_bready = 1'b0; s_rready = 1'b0;
        fork
            axi_wr(wa(3), 32'h2);
            axi_rd(wa(4 + N_CH));
            begin
                n = 0;
                while (!(s_bvalid && s_rvalid) && n < 40) begin @(negedge ACLK); n++; end
                if (n >= 40) fail_now("bp_resp_timeout");
                s_awaddr = 6'h3C; s_wdata = '0; s_awvalid = 1'b1; s_wvalid = 1'b1;
                s_araddr = 6'h3C; s_arvalid = 1'b1;
                repeat (5) begin
                    @(negedge ACLK);
                    chk("bp_bvalid_held", 64'(s_bvalid), 64'(1));
                    chk("bp_rvalid_held", 64'(s_rvalid), 64'(1));
                    chk("bp_no_accept", 64'({s_awready, s_arready}), 64'(0));
                end
                s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
                s_bready = 1'b1; s_rready = 1'b1;
            end
        join

        // Asynchronous reset right after a data write is accepted
        @(posedge ACLK); #1;
        s_awaddr = wa(4); s_wdata = $urandom; s_awvalid = 1'b1; s_wvalid = 1'b1;
        s_araddr = wa(1); s_arvalid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge ACLK);
            if (s_awready) break;
            if (++n > 40) begin fail_now("rst_aw_timeout"); break; end
        end
        @(posedge ACLK); #1;
        chk("mem_we_before_reset", 64'(mem_we), 64'(1));
        #1 ARESET = 1'b1;
        #1 check_all_zero("async_reset");
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        bq.delete(); rq.delete(); mq.delete();
        model_reset();
        repeat (3) @(posedge ACLK);
        @(negedge ACLK) ARESET = 1'b0;
        axi_rd(wa(4 + N_CH));
        axi_rd(wa(1));
        repeat (3) @(negedge ACLK);
        chk("queues_drained", 64'(bq.size() + rq.size() + mq.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
